// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates the instruction-fetch port (I, read-only) and
// the load/store port (D, read/write) onto a single-ported memory, sequences
// the start/ready handshake, returns data with a one-cycle ack to the owner,
// and aborts a transaction whose memory never finishes.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_rwn,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_start,
  output logic          mem_rwn,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_d,
  output logic          mem_err
);

  // Watchdog wide enough to hold TIMEOUT.
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;       // 1 = previous grant went to D
  logic            grant_d_q, grant_d_d;     // owner of current/last transaction
  logic            mem_start_q, mem_start_d;
  logic            mem_rwn_q, mem_rwn_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            i_ack_q, i_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            busy_seen_q, busy_seen_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            mem_err_q, mem_err_d;
  logic            pick_d_s;

  // Next-state and next-output computation for the arbiter/sequencer FSM.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    grant_d_d   = grant_d_q;
    mem_start_d = 1'b0;
    mem_rwn_d   = mem_rwn_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_seen_d = busy_seen_q;
    wd_d        = wd_q;
    mem_err_d   = mem_err_q;
    pick_d_s    = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time gets the memory.
        if (i_req && d_req) begin
          pick_d_s = ~last_d_q;
        end else begin
          pick_d_s = d_req;
        end
        if (i_req || d_req) begin
          grant_d_d   = pick_d_s;
          last_d_d    = pick_d_s;
          mem_addr_d  = pick_d_s ? d_addr : i_addr;
          mem_rwn_d   = pick_d_s ? d_rwn : 1'b1;
          mem_wdata_d = pick_d_s ? d_wdata : {DW{1'b0}};
          mem_start_d = 1'b1;
          busy_seen_d = 1'b0;
          wd_d        = {WDW{1'b0}};
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        // Memory accepts the strobe on the edge where it reports ready.
        if (mem_ready) begin
          mem_start_d = 1'b0;
          state_d     = WAIT;
        end else begin
          mem_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end

      WAIT: begin
        // Completion means the memory went busy and has come back idle.
        if (busy_seen_q && mem_ready) begin
          if (mem_rwn_q) begin
            if (grant_d_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = mem_rdata;
            end
          end else begin
            d_rdata_d = d_rdata_q;
          end
          i_ack_d = ~grant_d_q;
          d_ack_d = grant_d_q;
          state_d = RESP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          // Hung memory: flag it and hand back an all-ones read value.
          mem_err_d = 1'b1;
          if (mem_rwn_q) begin
            if (grant_d_q) begin
              d_rdata_d = {DW{1'b1}};
            end else begin
              i_rdata_d = {DW{1'b1}};
            end
          end else begin
            d_rdata_d = d_rdata_q;
          end
          i_ack_d = ~grant_d_q;
          d_ack_d = grant_d_q;
          state_d = RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
          if (!mem_ready) begin
            busy_seen_d = 1'b1;
          end else begin
            busy_seen_d = busy_seen_q;
          end
          state_d = WAIT;
        end
      end

      RESP: begin
        busy_seen_d = 1'b0;
        wd_d        = {WDW{1'b0}};
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      grant_d_q   <= 1'b0;
      mem_start_q <= 1'b0;
      mem_rwn_q   <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= {DW{1'b0}};
      d_rdata_q   <= {DW{1'b0}};
      busy_seen_q <= 1'b0;
      wd_q        <= {WDW{1'b0}};
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      grant_d_q   <= grant_d_d;
      mem_start_q <= mem_start_d;
      mem_rwn_q   <= mem_rwn_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_seen_q <= busy_seen_d;
      wd_q        <= wd_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_start = mem_start_q;
  assign mem_rwn   = mem_rwn_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_d   = grant_d_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a behavioural 256x16 memory
// whose busy time is addr[1:0]+1 cycles, plus a hang mode for the watchdog.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_rwn;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_start;
  logic        mem_rwn;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        grant_d;
  logic        mem_err;

  logic        hang;
  logic [15:0] mem_arr [256];
  logic [1:0]  busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.AW(8), .DW(16), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rwn(d_rwn), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_d(grant_d), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Memory model: accepts start while ready, then busy addr[1:0]+1 cycles.
  always @(posedge clk) begin
    if (reset) begin
      mem_ready     <= 1'b1;
      busy_cnt      <= 2'd0;
      mem_rdata     <= 16'h0000;
      mem_arr[0]    <= 16'hA141;
      mem_arr[244]  <= 16'h0000;
      mem_arr[247]  <= 16'h7777;
      mem_arr[249]  <= 16'h0005;
    end else if (mem_ready && mem_start) begin
      mem_ready <= 1'b0;
      busy_cnt  <= mem_addr[1:0];
      if (mem_rwn) begin
        mem_rdata <= mem_arr[mem_addr];
      end else begin
        mem_arr[mem_addr] <= mem_wdata;
        mem_rdata         <= 16'hDEAD;
      end
    end else if (!mem_ready && !hang) begin
      if (busy_cnt == 2'd0) begin
        mem_ready <= 1'b1;
      end else begin
        busy_cnt <= busy_cnt - 2'd1;
      end
    end
  end

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one request from a fresh IDLE cycle (cycle 0) and reports timing.
  task automatic run_txn(input bit port_d, input bit rwn, input logic [7:0] addr,
                         input logic [15:0] wdata, output int ack_cyc,
                         output int start_cyc, output bit other_ack, output bit gd);
    ack_cyc = -1; start_cyc = -1; other_ack = 1'b0; gd = 1'b0;
    @(negedge clk);
    if (port_d) begin
      d_req = 1'b1; d_rwn = rwn; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_start && start_cyc < 0) start_cyc = c;
      if (port_d ? d_ack : i_ack) begin
        ack_cyc = c; gd = grant_d; i_req = 1'b0; d_req = 1'b0;
      end
      if (port_d ? i_ack : d_ack) other_ack = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({i_ack, d_ack, mem_start, mem_rwn, grant_d, mem_err} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 000000",
               {i_ack, d_ack, mem_start, mem_rwn, grant_d, mem_err});
    end
    n_tests++;
    if ({i_rdata, d_rdata, mem_wdata, mem_addr} !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, expected 0", {i_rdata, d_rdata, mem_wdata, mem_addr});
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    int ac, sc; bit oa, gd;
    run_txn(1'b0, 1'b1, 8'd0, 16'h0000, ac, sc, oa, gd);
    n_tests++;
    if (sc !== 1) begin n_fail++; $display("FAIL fetch_start_cycle: got %0d, expected 1", sc); end
    n_tests++;
    if (ac !== 4) begin n_fail++; $display("FAIL fetch_ack_cycle: got %0d, expected 4", ac); end
    n_tests++;
    if (i_rdata !== 16'hA141) begin n_fail++; $display("FAIL fetch_rdata: got %h, expected a141", i_rdata); end
    n_tests++;
    if (oa !== 1'b0) begin n_fail++; $display("FAIL fetch_no_d_ack: got %b, expected 0", oa); end
    n_tests++;
    if (gd !== 1'b0) begin n_fail++; $display("FAIL fetch_grant_d: got %b, expected 0", gd); end
  endtask

  task automatic test_load_latency;
    int ac, sc; bit oa, gd;
    run_txn(1'b1, 1'b1, 8'd249, 16'h0000, ac, sc, oa, gd);
    n_tests++;
    if (ac !== 5) begin n_fail++; $display("FAIL load249_ack_cycle: got %0d, expected 5", ac); end
    n_tests++;
    if (d_rdata !== 16'h0005) begin n_fail++; $display("FAIL load249_rdata: got %h, expected 0005", d_rdata); end
    n_tests++;
    if (gd !== 1'b1) begin n_fail++; $display("FAIL load249_grant_d: got %b, expected 1", gd); end
    n_tests++;
    if (oa !== 1'b0) begin n_fail++; $display("FAIL load249_no_i_ack: got %b, expected 0", oa); end
    run_txn(1'b1, 1'b1, 8'd244, 16'h0000, ac, sc, oa, gd);
    n_tests++;
    if (ac !== 4) begin n_fail++; $display("FAIL load244_ack_cycle: got %0d, expected 4", ac); end
    n_tests++;
    if (d_rdata !== 16'h0000) begin n_fail++; $display("FAIL load244_rdata: got %h, expected 0000", d_rdata); end
  endtask

  task automatic test_store_load;
    int ac, sc; bit oa, gd;
    run_txn(1'b1, 1'b0, 8'd250, 16'h1234, ac, sc, oa, gd);
    n_tests++;
    if (ac !== 6) begin n_fail++; $display("FAIL store_ack_cycle: got %0d, expected 6", ac); end
    n_tests++;
    if (d_rdata !== 16'h0000) begin n_fail++; $display("FAIL store_rdata_kept: got %h, expected 0000", d_rdata); end
    n_tests++;
    if (mem_rwn !== 1'b0) begin n_fail++; $display("FAIL store_mem_rwn: got %b, expected 0", mem_rwn); end
    run_txn(1'b1, 1'b1, 8'd250, 16'h0000, ac, sc, oa, gd);
    n_tests++;
    if (ac !== 6) begin n_fail++; $display("FAIL reload_ack_cycle: got %0d, expected 6", ac); end
    n_tests++;
    if (d_rdata !== 16'h1234) begin n_fail++; $display("FAIL reload_rdata: got %h, expected 1234", d_rdata); end
  endtask

  task automatic test_contention;
    int exp_cyc[4] = '{5, 10, 16, 21};
    bit exp_d[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    int n_ack;
    bit prev_ack;
    apply_reset();
    @(negedge clk);
    i_req = 1'b1; i_addr = 8'd0;
    d_req = 1'b1; d_rwn = 1'b1; d_addr = 8'd249;
    n_ack = 0; prev_ack = 1'b0;
    for (int c = 1; c <= 60 && n_ack < 4; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        n_tests++;
        if (i_ack && d_ack) begin n_fail++; $display("FAIL tie_both_ack: got 1, expected 0 at cycle %0d", c); end
        n_tests++;
        if (prev_ack !== 1'b0) begin n_fail++; $display("FAIL tie_ack_width: got 2+ cycles, expected 1 at cycle %0d", c); end
        n_tests++;
        if (d_ack !== exp_d[n_ack]) begin n_fail++; $display("FAIL tie_order%0d: got d_ack=%b, expected %b", n_ack, d_ack, exp_d[n_ack]); end
        n_tests++;
        if (grant_d !== exp_d[n_ack]) begin n_fail++; $display("FAIL tie_grant_d%0d: got %b, expected %b", n_ack, grant_d, exp_d[n_ack]); end
        n_tests++;
        if (c !== exp_cyc[n_ack]) begin n_fail++; $display("FAIL tie_cycle%0d: got %0d, expected %0d", n_ack, c, exp_cyc[n_ack]); end
        n_tests++;
        if ((d_ack ? d_rdata : i_rdata) !== (d_ack ? 16'h0005 : 16'hA141)) begin
          n_fail++; $display("FAIL tie_rdata%0d: got %h", n_ack, d_ack ? d_rdata : i_rdata);
        end
        n_ack++;
        if (n_ack == 4) begin i_req = 1'b0; d_req = 1'b0; end
      end
      prev_ack = i_ack || d_ack;
    end
    i_req = 1'b0; d_req = 1'b0;
    n_tests++;
    if (n_ack !== 4) begin n_fail++; $display("FAIL tie_ack_count: got %0d, expected 4", n_ack); end
  endtask

  task automatic test_reset_mid_wait;
    int ac, sc; bit oa, gd;
    bit seen_ack;
    @(negedge clk);
    d_req = 1'b1; d_rwn = 1'b1; d_addr = 8'd247;
    seen_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (i_ack || d_ack) seen_ack = 1'b1;
    end
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    if (i_ack || d_ack) seen_ack = 1'b1;
    reset = 1'b0;
    n_tests++;
    if (seen_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_no_ack: got %b, expected 0", seen_ack); end
    n_tests++;
    if ({mem_start, mem_rwn, grant_d, mem_err, mem_addr} !== 12'd0) begin
      n_fail++; $display("FAIL midreset_ctrl: got %h, expected 0", {mem_start, mem_rwn, grant_d, mem_err, mem_addr});
    end
    n_tests++;
    if ({i_rdata, d_rdata} !== 32'd0) begin
      n_fail++; $display("FAIL midreset_rdata: got %h, expected 0", {i_rdata, d_rdata});
    end
    run_txn(1'b0, 1'b1, 8'd0, 16'h0000, ac, sc, oa, gd);
    n_tests++;
    if (ac !== 4) begin n_fail++; $display("FAIL postreset_ack_cycle: got %0d, expected 4", ac); end
    n_tests++;
    if (i_rdata !== 16'hA141) begin n_fail++; $display("FAIL postreset_rdata: got %h, expected a141", i_rdata); end
    n_tests++;
    if (oa !== 1'b0) begin n_fail++; $display("FAIL postreset_no_d_ack: got %b, expected 0", oa); end
  endtask

  task automatic test_timeout;
    int ac, sc; bit oa, gd;
    n_tests++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL pre_timeout_err: got %b, expected 0", mem_err); end
    hang = 1'b1;
    run_txn(1'b1, 1'b1, 8'd249, 16'h0000, ac, sc, oa, gd);
    hang = 1'b0;
    n_tests++;
    if (ac !== 17) begin n_fail++; $display("FAIL timeout_ack_cycle: got %0d, expected 17", ac); end
    n_tests++;
    if (d_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL timeout_rdata: got %h, expected ffff", d_rdata); end
    n_tests++;
    if (mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b, expected 1", mem_err); end
    run_txn(1'b0, 1'b1, 8'd0, 16'h0000, ac, sc, oa, gd);
    n_tests++;
    if (ac < 0) begin n_fail++; $display("FAIL after_timeout_ack: got none, expected ack"); end
    n_tests++;
    if (i_rdata !== 16'hA141) begin n_fail++; $display("FAIL after_timeout_rdata: got %h, expected a141", i_rdata); end
    n_tests++;
    if (mem_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, expected 1", mem_err); end
    apply_reset();
    n_tests++;
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b, expected 0", mem_err); end
  endtask

  initial begin
    reset = 1'b1; hang = 1'b0;
    i_req = 1'b0; i_addr = 8'd0;
    d_req = 1'b0; d_rwn = 1'b1; d_addr = 8'd0; d_wdata = 16'h0000;
    test_reset();
    test_fetch();
    test_load_latency();
    test_store_load();
    test_contention();
    test_reset_mid_wait();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
